sid_svf_mc: RTL

//  Parametrised SID state-variable filter and mixer for NV voices plus one external input.

---
 rtl/sid_svf_mc_if.sv | 37 +++
 rtl/sid_svf_mc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_svf_mc_if.sv
// ---------------------------------------------------------------------------
// sid_svf_mc_if
// Groups the sample-set handshake, register inputs and mixed output of the
// SID state-variable filter/mixer into one bundle.
//   master : the voice side; drives in_valid, voices, ext_in, fc, res, filt,
//            mode, v3off and vol, and receives in_ready, sound and out_valid
//   slave  : the filter/mixer (sid_svf_mc)
// Parameters NV, DW and AW must match those of the attached sid_svf_mc.
// ---------------------------------------------------------------------------
interface sid_svf_mc_if #(
  parameter int NV = 3,
  parameter int DW = 12,
  parameter int AW = 18
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NV*DW-1:0]     voices;
  logic [DW-1:0]        ext_in;
  logic [10:0]          fc;
  logic [3:0]           res;
  logic [NV:0]          filt;
  logic [2:0]           mode;
  logic                 v3off;
  logic [3:0]           vol;
  logic signed [AW-1:0] sound;
  logic                 out_valid;

  modport master (
    output in_valid, voices, ext_in, fc, res, filt, mode, v3off, vol,
    input  in_ready, sound, out_valid
  );

  modport slave (
    input  in_valid, voices, ext_in, fc, res, filt, mode, v3off, vol,
    output in_ready, sound, out_valid
  );
endinterface

// File: rtl/sid_svf_mc.sv
// ---------------------------------------------------------------------------
// sid_svf_mc
// SID state-variable filter and output mixer for NV voices plus one external
// input (channel NV). Each accepted sample set is processed by a time-
// multiplexed sequence:
//   IDLE -> COEF -> MIX(k=0..NV) -> BP -> LP -> HP -> FSUM -> VOL -> IDLE
// Every product term uses the same signed AW x AW multiplier.
// out_valid pulses NV+7 clocks after the accept edge, and sound changes in
// that same cycle. The next sample can be accepted NV+8 clocks after the
// previous one.
//
// Ports
//   clk   : clock
//   rst   : synchronous reset, active-high
//   bus   : sid_svf_mc_if.slave
//           in_valid/in_ready  sample-set handshake (in_ready only in IDLE)
//           voices, ext_in     unsigned offset-binary samples
//           fc, res            cutoff and resonance register values
//           filt               bit k routes channel k through the filter
//           mode               {hp, bp, lp} filter output select
//           v3off              mutes voice 2 when it is not filtered
//           vol                master volume 0..15
//           sound, out_valid   signed mixed output and its one-cycle strobe
//
// Configuration macro SID_SVF_SAT_EN
//   defined   : state updates and sound saturate to the signed AW range
//   undefined : state registers wrap modulo 2^AW; if the scaled output does
//               not fit in AW bits, sound keeps its previous value
// Requires AW > DW + 2 and AW >= 18, so that the cutoff constant and the
// shifted voice samples fit.
// ---------------------------------------------------------------------------
module sid_svf_mc #(
  parameter int NV = 3,
  parameter int DW = 12,
  parameter int AW = 18
) (
  input  logic        clk,
  input  logic        rst,
  sid_svf_mc_if.slave bus
);

  localparam int KW = $clog2(NV + 1);
  // Width that holds any sum or difference of a full product and AW terms.
  localparam int WW = 2 * AW + 2;
  localparam logic signed [WW-1:0] MAX_W = {{(WW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_W = {{(WW-AW+1){1'b1}}, {(AW-1){1'b0}}};
  localparam logic signed [AW-1:0] W0_K  = AW'(82355);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COEF,
    S_MIX,
    S_BP,
    S_LP,
    S_HP,
    S_FSUM,
    S_VOL
  } state_t;

  state_t state, state_nxt;

  // Input set captured at the accept edge.
  logic [NV*DW-1:0] voices_q;
  logic [DW-1:0]    ext_q;
  logic [10:0]      fc_q;
  logic [3:0]       res_q;
  logic [NV:0]      filt_q;
  logic [2:0]       mode_q;
  logic             v3off_q;
  logic [3:0]       vol_q;

  logic [KW-1:0]        k;
  logic signed [AW-1:0] w0, q;
  logic signed [AW-1:0] vi, vnf, vf;
  logic signed [AW-1:0] vhp, vbp, vlp;
  logic signed [AW-1:0] sound_q;
  logic                 out_valid_q;
  logic                 in_ready_c;

  logic [DW-1:0]          samp;
  logic signed [DW-1:0]   samp_off;
  logic signed [AW-1:0]   s_mix;
  logic [11:0]            fc_inc;
  logic signed [AW-1:0]   mix_sum;
  logic signed [WW-1:0]   fsum;
  logic signed [AW-1:0]   mul_a, mul_b;
  logic signed [2*AW-1:0] mul_p;
  logic signed [WW-1:0]   scaled;

  function automatic logic signed [WW-1:0] ext_aw(input logic signed [AW-1:0] x);
    return {{(WW-AW){x[AW-1]}}, x};
  endfunction

  function automatic logic signed [WW-1:0] ext_pr(input logic signed [2*AW-1:0] x);
    return {{(WW-2*AW){x[2*AW-1]}}, x};
  endfunction

  // Brings a wide intermediate result back into an AW-bit register.
  function automatic logic signed [AW-1:0] fit(input logic signed [WW-1:0] v);
`ifdef SID_SVF_SAT_EN
    if (v > MAX_W)      return MAX_W[AW-1:0];
    else if (v < MIN_W) return MIN_W[AW-1:0];
    else                return v[AW-1:0];
`else
    return v[AW-1:0];
`endif
  endfunction

  // Resonance feedback gain, round(1448 * 2^(-r/8)); 1024 is unity.
  function automatic logic [10:0] qtab(input logic [3:0] r);
    logic [10:0] v;
    case (r)
      4'd0:    v = 11'd1448;
      4'd1:    v = 11'd1328;
      4'd2:    v = 11'd1218;
      4'd3:    v = 11'd1117;
      4'd4:    v = 11'd1024;
      4'd5:    v = 11'd939;
      4'd6:    v = 11'd861;
      4'd7:    v = 11'd790;
      4'd8:    v = 11'd724;
      4'd9:    v = 11'd664;
      4'd10:   v = 11'd609;
      4'd11:   v = 11'd558;
      4'd12:   v = 11'd512;
      4'd13:   v = 11'd469;
      4'd14:   v = 11'd430;
      default: v = 11'd395;
    endcase
    return v;
  endfunction

  // Channel k sample: voices 0..NV-1, then ext_in as channel NV.
  always_comb begin
    samp = ext_q;
    for (int i = 0; i < NV; i++) begin
      if (int'(k) == i) samp = voices_q[i*DW +: DW];
    end
  end

  // Flipping the MSB removes the 2^(DW-1) offset; then scale by 4.
  assign samp_off = {~samp[DW-1], samp[DW-2:0]};
  assign s_mix    = {{(AW-DW-2){samp_off[DW-1]}}, samp_off, 2'b00};
  assign fc_inc   = {1'b0, fc_q} + 12'd1;
  assign mix_sum  = fit(ext_aw(vnf) + ext_aw(vf));

  // Filter output selection for the FSUM step.
  always_comb begin
    fsum = '0;
    if (mode_q[0]) fsum = fsum + ext_aw(vlp);
    if (mode_q[1]) fsum = fsum + ext_aw(vbp);
    if (mode_q[2]) fsum = fsum + ext_aw(vhp);
  end

  // Operand steering for the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_COEF: begin
        mul_a = W0_K;
        mul_b = {{(AW-12){1'b0}}, fc_inc};
      end
      S_BP: begin
        mul_a = w0;
        mul_b = vhp;
      end
      S_LP: begin
        mul_a = w0;
        mul_b = vbp;
      end
      S_HP: begin
        mul_a = q;
        mul_b = vbp;
      end
      S_VOL: begin
        mul_a = mix_sum;
        mul_b = {{(AW-4){1'b0}}, vol_q};
      end
      default: ;
    endcase
  end

  assign mul_p  = mul_a * mul_b;
  assign scaled = ext_pr(mul_p >>> 3);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake logic.
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = S_COEF;
      end
      S_COEF:  state_nxt = S_MIX;
      S_MIX:   if (int'(k) == NV) state_nxt = S_BP;
      S_BP:    state_nxt = S_LP;
      S_LP:    state_nxt = S_HP;
      S_HP:    state_nxt = S_FSUM;
      S_FSUM:  state_nxt = S_VOL;
      S_VOL:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath. BP uses the previous sample's Vhp, while LP and HP use the Vbp
  // that BP just produced. Sound and out_valid are registered together when
  // leaving VOL.
  always_ff @(posedge clk) begin
    if (rst) begin
      voices_q    <= '0;
      ext_q       <= '0;
      fc_q        <= '0;
      res_q       <= '0;
      filt_q      <= '0;
      mode_q      <= '0;
      v3off_q     <= 1'b0;
      vol_q       <= '0;
      k           <= '0;
      w0          <= '0;
      q           <= '0;
      vi          <= '0;
      vnf         <= '0;
      vf          <= '0;
      vhp         <= '0;
      vbp         <= '0;
      vlp         <= '0;
      sound_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            voices_q <= bus.voices;
            ext_q    <= bus.ext_in;
            fc_q     <= bus.fc;
            res_q    <= bus.res;
            filt_q   <= bus.filt;
            mode_q   <= bus.mode;
            v3off_q  <= bus.v3off;
            vol_q    <= bus.vol;
          end
        end
        S_COEF: begin
          w0  <= mul_p[AW+11:12];
          q   <= {{(AW-11){1'b0}}, qtab(res_q)};
          vi  <= '0;
          vnf <= '0;
          k   <= '0;
        end
        S_MIX: begin
          if (filt_q[k])
            vi <= fit(ext_aw(vi) + ext_aw(s_mix));
          else if (!(NV >= 3 && int'(k) == 2 && v3off_q))
            vnf <= fit(ext_aw(vnf) + ext_aw(s_mix));
          k <= k + KW'(1);
        end
        S_BP:   vbp <= fit(ext_aw(vbp) - ext_pr(mul_p >>> 17));
        S_LP:   vlp <= fit(ext_aw(vlp) - ext_pr(mul_p >>> 17));
        S_HP:   vhp <= fit(ext_pr(mul_p >>> 10) - ext_aw(vlp) - ext_aw(vi));
        S_FSUM: vf  <= fit(fsum);
        S_VOL: begin
          out_valid_q <= 1'b1;
`ifdef SID_SVF_SAT_EN
          sound_q <= fit(scaled);
`else
          if (scaled <= MAX_W && scaled >= MIN_W) sound_q <= scaled[AW-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.sound     = sound_q;
  assign bus.out_valid = out_valid_q;

endmodule
